// File: rtl/e203_exu_pkg.sv
// Shared EXU writeback types: datapath widths and the writeback request
// carried by both input channels and the registered output stage.
package e203_exu_pkg;

  localparam int XLEN    = 32;
  localparam int RFIDX_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]    wdat;
    logic [RFIDX_W-1:0] rdidx;
  } wbck_req_t;

endpackage

// File: rtl/e203_exu_wbck_starv_cnt.sv
// Saturating count of cycles the ALU lost arbitration to the long pipe;
// raises force_alu once the ALU has been starved STARVE_MAX times in a row.
module e203_exu_wbck_starv_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_valid,
  input  logic       alu_xfer,
  input  logic       longp_xfer,
  output logic       force_alu,
  output logic [3:0] cnt
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  // Only cycles where the long pipe actually took the port count; stalls hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (alu_xfer) begin
      cnt <= 4'd0;
    end else if (alu_valid && longp_xfer && (cnt != CNT_MAX)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign force_alu = alu_valid && (cnt == CNT_MAX);

endmodule

// File: rtl/e203_exu_wbck_merge.sv
// Merges ALU and long-pipe writeback onto the single regfile write port
// through a one-entry output register; long pipe wins unless ALU is starved.
//
// Handshake: a channel transfers on a cycle where its valid and ready are both
// high; ready depends only on valids and output-stage occupancy, never on data,
// and a producer must hold valid and data stable until it sees ready.
module e203_exu_wbck_merge #(
  parameter int XLEN       = e203_exu_pkg::XLEN,
  parameter int RFIDX_W    = e203_exu_pkg::RFIDX_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_wbck_i_valid,
  output logic                  alu_wbck_i_ready,
  input  logic [XLEN-1:0]       alu_wbck_i_wdat,
  input  logic [RFIDX_W-1:0]    alu_wbck_i_rdidx,
  input  logic                  longp_wbck_i_valid,
  output logic                  longp_wbck_i_ready,
  input  logic [XLEN-1:0]       longp_wbck_i_wdat,
  input  logic [RFIDX_W-1:0]    longp_wbck_i_rdidx,
  output logic                  rf_wbck_o_valid,
  input  logic                  rf_wbck_o_ready,
  output logic [XLEN-1:0]       rf_wbck_o_wdat,
  output logic [RFIDX_W-1:0]    rf_wbck_o_rdidx,
  output logic [2**RFIDX_W-1:0] rf_pend_o
);

  import e203_exu_pkg::*;

  wbck_req_t alu_req;
  wbck_req_t longp_req;
  wbck_req_t sel_req;
  wbck_req_t out_q;
  logic      out_vld;

  logic       stage_free;
  logic       force_alu;
  logic       gnt_alu;
  logic       gnt_longp;
  logic       alu_xfer;
  logic       longp_xfer;
  logic       any_xfer;
  logic [3:0] starve_cnt;

  assign alu_req.wdat    = alu_wbck_i_wdat;
  assign alu_req.rdidx   = alu_wbck_i_rdidx;
  assign longp_req.wdat  = longp_wbck_i_wdat;
  assign longp_req.rdidx = longp_wbck_i_rdidx;

  // Draining and refilling the output stage in the same cycle is allowed.
  assign stage_free = !out_vld || rf_wbck_o_ready;

  assign gnt_alu   = alu_wbck_i_valid && (force_alu || !longp_wbck_i_valid);
  assign gnt_longp = longp_wbck_i_valid && !force_alu;

  assign alu_wbck_i_ready   = gnt_alu && stage_free;
  assign longp_wbck_i_ready = gnt_longp && stage_free;

  assign alu_xfer   = alu_wbck_i_valid && alu_wbck_i_ready;
  assign longp_xfer = longp_wbck_i_valid && longp_wbck_i_ready;
  assign any_xfer   = alu_xfer || longp_xfer;
  assign sel_req    = alu_xfer ? alu_req : longp_req;

  e203_exu_wbck_starv_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starv (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_wbck_i_valid),
    .alu_xfer   (alu_xfer),
    .longp_xfer (longp_xfer),
    .force_alu  (force_alu),
    .cnt        (starve_cnt)
  );

  // Writes to x0 complete their handshake but never occupy the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_q   <= '0;
    end else if (any_xfer) begin
      if (sel_req.rdidx != '0) begin
        out_vld <= 1'b1;
        out_q   <= sel_req;
      end else if (rf_wbck_o_ready) begin
        out_vld <= 1'b0;
      end
    end else if (rf_wbck_o_ready && out_vld) begin
      out_vld <= 1'b0;
    end
  end

  assign rf_wbck_o_valid = out_vld;
  assign rf_wbck_o_wdat  = out_q.wdat;
  assign rf_wbck_o_rdidx = out_q.rdidx;

  always_comb begin
    rf_pend_o = '0;
    if (out_vld) begin
      rf_pend_o[out_q.rdidx] = 1'b1;
    end
  end

endmodule

// File: tb/tb_e203_exu_wbck_merge.sv
// Directed bench for the writeback merge: reset, priority, starvation,
// backpressure, x0 drop and pending-mask behaviour.
module tb_e203_exu_wbck_merge;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [31:0] alu_wdat;
  logic [4:0]  alu_rdidx;
  logic        longp_valid;
  logic        longp_ready;
  logic [31:0] longp_wdat;
  logic [4:0]  longp_rdidx;
  logic        rf_valid;
  logic        rf_ready;
  logic [31:0] rf_wdat;
  logic [4:0]  rf_rdidx;
  logic [31:0] rf_pend;

  int total = 0;
  int bad   = 0;

  e203_exu_wbck_merge #(
    .XLEN       (32),
    .RFIDX_W    (5),
    .STARVE_MAX (4)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .alu_wbck_i_valid   (alu_valid),
    .alu_wbck_i_ready   (alu_ready),
    .alu_wbck_i_wdat    (alu_wdat),
    .alu_wbck_i_rdidx   (alu_rdidx),
    .longp_wbck_i_valid (longp_valid),
    .longp_wbck_i_ready (longp_ready),
    .longp_wbck_i_wdat  (longp_wdat),
    .longp_wbck_i_rdidx (longp_rdidx),
    .rf_wbck_o_valid    (rf_valid),
    .rf_wbck_o_ready    (rf_ready),
    .rf_wbck_o_wdat     (rf_wdat),
    .rf_wbck_o_rdidx    (rf_rdidx),
    .rf_pend_o          (rf_pend)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] idx, input logic [31:0] dat);
    alu_valid = v;
    alu_rdidx = idx;
    alu_wdat  = dat;
  endtask

  task automatic drive_longp(input logic v, input logic [4:0] idx, input logic [31:0] dat);
    longp_valid = v;
    longp_rdidx = idx;
    longp_wdat  = dat;
  endtask

  // starvation pattern with STARVE_MAX=4: four long-pipe wins, then one ALU win
  logic       exp_alu_win[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] exp_cnt[10]     = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};

  initial begin
    rst_n    = 1'b0;
    rf_ready = 1'b1;
    drive_alu(1'b0, 5'd0, 32'h0);
    drive_longp(1'b0, 5'd0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_valid", {31'b0, rf_valid}, 32'h0);
    check("rst_pend", rf_pend, 32'h0);
    check("rst_wdat", rf_wdat, 32'h0);
    check("rst_cnt", {28'b0, dut.u_starv.cnt}, 32'h0);

    // fill the stage, then reset asynchronously while it holds an entry
    tick();
    drive_alu(1'b1, 5'd5, 32'h1234);
    @(negedge clk);
    check("first_alu_ready", {31'b0, alu_ready}, 32'h1);
    check("first_longp_ready", {31'b0, longp_ready}, 32'h0);
    tick();
    drive_alu(1'b0, 5'd0, 32'h0);
    rf_ready = 1'b0;
    @(negedge clk);
    check("first_valid", {31'b0, rf_valid}, 32'h1);
    check("first_rdidx", {27'b0, rf_rdidx}, 32'd5);
    check("first_wdat", rf_wdat, 32'h1234);
    check("first_pend", rf_pend, 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, rf_valid}, 32'h0);
    check("async_rst_pend", rf_pend, 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    rf_ready = 1'b1;
    tick();
    drive_alu(1'b1, 5'd5, 32'h1234);
    tick();
    drive_alu(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("post_rst_valid", {31'b0, rf_valid}, 32'h1);
    check("post_rst_rdidx", {27'b0, rf_rdidx}, 32'd5);
    check("post_rst_wdat", rf_wdat, 32'h1234);

    // priority: long pipe first, ALU on the following cycle
    tick();
    drive_alu(1'b1, 5'd3, 32'hA);
    drive_longp(1'b1, 5'd7, 32'hB);
    @(negedge clk);
    check("prio_longp_ready", {31'b0, longp_ready}, 32'h1);
    check("prio_alu_ready", {31'b0, alu_ready}, 32'h0);
    tick();
    drive_longp(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("prio_out1_rdidx", {27'b0, rf_rdidx}, 32'd7);
    check("prio_out1_wdat", rf_wdat, 32'hB);
    check("prio_alu_ready2", {31'b0, alu_ready}, 32'h1);
    check("prio_cnt1", {28'b0, dut.u_starv.cnt}, 32'd1);
    tick();
    drive_alu(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("prio_out2_valid", {31'b0, rf_valid}, 32'h1);
    check("prio_out2_rdidx", {27'b0, rf_rdidx}, 32'd3);
    check("prio_out2_wdat", rf_wdat, 32'hA);
    check("prio_cnt2", {28'b0, dut.u_starv.cnt}, 32'd0);
    tick();
    @(negedge clk);
    check("prio_drained", {31'b0, rf_valid}, 32'h0);

    // starvation: both channels valid continuously
    tick();
    drive_alu(1'b1, 5'd3, 32'hA);
    drive_longp(1'b1, 5'd7, 32'hB);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("starve_alu_rdy%0d", k), {31'b0, alu_ready}, {31'b0, exp_alu_win[k]});
      check($sformatf("starve_lp_rdy%0d", k), {31'b0, longp_ready}, {31'b0, !exp_alu_win[k]});
      check($sformatf("starve_cnt%0d", k), {28'b0, dut.u_starv.cnt}, {28'b0, exp_cnt[k]});
      if (k > 0) begin
        check($sformatf("starve_rdidx%0d", k), {27'b0, rf_rdidx},
              exp_alu_win[k-1] ? 32'd3 : 32'd7);
      end
    end

    // backpressure: get the counter to 1, then stall with ALU waiting
    tick();
    drive_alu(1'b1, 5'd9, 32'h99);
    drive_longp(1'b1, 5'd12, 32'hC);
    @(negedge clk);
    check("bp_pre_cnt", {28'b0, dut.u_starv.cnt}, 32'd0);
    check("bp_longp_ready", {31'b0, longp_ready}, 32'h1);
    tick();
    drive_longp(1'b0, 5'd0, 32'h0);
    rf_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp_alu_rdy%0d", k), {31'b0, alu_ready}, 32'h0);
      check($sformatf("bp_lp_rdy%0d", k), {31'b0, longp_ready}, 32'h0);
      check($sformatf("bp_valid%0d", k), {31'b0, rf_valid}, 32'h1);
      check($sformatf("bp_rdidx%0d", k), {27'b0, rf_rdidx}, 32'd12);
      check($sformatf("bp_wdat%0d", k), rf_wdat, 32'hC);
      check($sformatf("bp_cnt%0d", k), {28'b0, dut.u_starv.cnt}, 32'd1);
    end
    tick();
    rf_ready = 1'b1;
    @(negedge clk);
    check("bp_refill_ready", {31'b0, alu_ready}, 32'h1);
    tick();
    drive_alu(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("bp_refill_valid", {31'b0, rf_valid}, 32'h1);
    check("bp_refill_rdidx", {27'b0, rf_rdidx}, 32'd9);
    check("bp_refill_wdat", rf_wdat, 32'h99);
    check("bp_refill_cnt", {28'b0, dut.u_starv.cnt}, 32'd0);

    // x0 drop while draining, then again with an empty stage
    tick();
    drive_alu(1'b1, 5'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    check("x0_ready_drain", {31'b0, alu_ready}, 32'h1);
    tick();
    @(negedge clk);
    check("x0_valid_drain", {31'b0, rf_valid}, 32'h0);
    check("x0_pend_drain", rf_pend, 32'h0);
    check("x0_ready_empty", {31'b0, alu_ready}, 32'h1);
    tick();
    drive_alu(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("x0_valid_empty", {31'b0, rf_valid}, 32'h0);
    check("x0_pend_empty", rf_pend, 32'h0);

    // pending mask for x31 while held, cleared after drain
    tick();
    drive_longp(1'b1, 5'd31, 32'h5555);
    tick();
    drive_longp(1'b0, 5'd0, 32'h0);
    rf_ready = 1'b0;
    @(negedge clk);
    check("pend31_held0", rf_pend, 32'h8000_0000);
    check("pend31_wdat", rf_wdat, 32'h5555);
    tick();
    @(negedge clk);
    check("pend31_held1", rf_pend, 32'h8000_0000);
    tick();
    rf_ready = 1'b1;
    @(negedge clk);
    check("pend31_draining", rf_pend, 32'h8000_0000);
    tick();
    @(negedge clk);
    check("pend31_cleared", rf_pend, 32'h0);
    check("pend31_valid", {31'b0, rf_valid}, 32'h0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
